// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction memory: instruction width, bubble value
// and the program-loader state encoding.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } load_state_t;

endpackage

// File: rtl/inst_loader_fsm.sv
// Byte-serial program loader: assembles MSB-first bytes into words and drives the
// single write port of the instruction array.
//
// state    | meaning
// ST_RUN   | normal execution, loader idle
// ST_LOAD  | accepting bytes, writing each completed word at WordCount
// ST_FLUSH | one cycle: write the zero-padded partial word, then back to ST_RUN
module inst_loader_fsm
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LoadStart,
  input  logic              LoadValid,
  input  logic [7:0]        LoadByte,
  input  logic              LoadDone,
  output logic              LoadReady,
  output logic              Loading,
  output logic              LoadOverflow,
  output logic [ADDR_W:0]   WordCount,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int NB   = DATA_W / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB - 1);

  load_state_t       state;
  logic [BC_W-1:0]   byte_cnt;
  logic [BC_W-1:0]   cnt_next;
  logic [DATA_W-1:0] asm_word;
  logic              full;
  logic              take;
  logic              word_done;

  // Memory is full once the pointer has wrapped into its extra MSB.
  assign full      = WordCount[ADDR_W];
  assign take      = (state == ST_LOAD) && LoadValid && !LoadStart;
  assign word_done = take && !full && (byte_cnt == BC_LAST);
  assign wr_addr   = WordCount[ADDR_W-1:0];

  always_comb begin
    cnt_next = byte_cnt;
    if (take && !full)
      cnt_next = word_done ? '0 : byte_cnt + 1'b1;
  end

  always_comb begin
    wr_en   = word_done || ((state == ST_FLUSH) && !LoadStart && !full);
    wr_data = asm_word;
    // The completing byte bypasses the assembly register so the word lands this edge.
    if (state != ST_FLUSH)
      wr_data[7:0] = LoadByte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      byte_cnt     <= '0;
      asm_word     <= '0;
      WordCount    <= '0;
      LoadOverflow <= 1'b0;
      Loading      <= 1'b0;
      LoadReady    <= 1'b0;
    end else if (LoadStart) begin
      state        <= ST_LOAD;
      byte_cnt     <= '0;
      asm_word     <= '0;
      WordCount    <= '0;
      LoadOverflow <= 1'b0;
      Loading      <= 1'b1;
      LoadReady    <= 1'b1;
    end else begin
      case (state)
        ST_LOAD: begin
          if (take) begin
            if (full) begin
              LoadOverflow <= 1'b1;
            end else if (word_done) begin
              asm_word  <= '0;
              WordCount <= WordCount + 1'b1;
            end else begin
              for (int b = 0; b < NB; b++)
                if (byte_cnt == BC_W'(b))
                  asm_word[DATA_W-8-8*b +: 8] <= LoadByte;
            end
          end
          byte_cnt <= cnt_next;
          // A byte arriving with LoadDone is counted before deciding whether to flush.
          if (LoadDone) begin
            LoadReady <= 1'b0;
            if (cnt_next == '0) begin
              state   <= ST_RUN;
              Loading <= 1'b0;
            end else begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (full)
            LoadOverflow <= 1'b1;
          else
            WordCount <= WordCount + 1'b1;
          asm_word  <= '0;
          byte_cnt  <= '0;
          state     <= ST_RUN;
          Loading   <= 1'b0;
          LoadReady <= 1'b0;
        end
        default: begin
          LoadReady <= 1'b0;
          Loading   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/inst_mem_loadable.sv
// Run-time loadable instruction memory: synchronous fetch port with stall hold and
// address checking, plus a byte-serial loader writing the same array.
module inst_mem_loadable
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 9,
  parameter int              DATA_W   = INST_W,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(cpu_pkg::NOP_INST)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              FetchEn,
  input  logic [31:0]       ReadAddr,
  output logic [DATA_W-1:0] ReadInst,
  output logic              InstValid,
  output logic              AddrErr,
  input  logic              LoadStart,
  input  logic              LoadValid,
  input  logic [7:0]        LoadByte,
  output logic              LoadReady,
  input  logic              LoadDone,
  output logic              Loading,
  output logic              LoadOverflow,
  output logic [ADDR_W:0]   WordCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              addr_bad;
  logic [ADDR_W-1:0] fetch_idx;

  inst_loader_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .LoadStart    (LoadStart),
    .LoadValid    (LoadValid),
    .LoadByte     (LoadByte),
    .LoadDone     (LoadDone),
    .LoadReady    (LoadReady),
    .Loading      (Loading),
    .LoadOverflow (LoadOverflow),
    .WordCount    (WordCount),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  assign addr_bad  = (ReadAddr[1:0] != 2'b00) || ((ReadAddr >> (ADDR_W + 2)) != 32'd0);
  assign fetch_idx = ReadAddr[ADDR_W+1:2];

  // Contents survive reset so a loaded program outlives a CPU reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadInst  <= NOP_INST;
      InstValid <= 1'b0;
      AddrErr   <= 1'b0;
    end else if (LoadStart || Loading) begin
      ReadInst  <= NOP_INST;
      InstValid <= 1'b0;
    end else if (FetchEn) begin
      if (addr_bad) begin
        ReadInst  <= NOP_INST;
        InstValid <= 1'b0;
        AddrErr   <= 1'b1;
      end else begin
        ReadInst  <= mem[fetch_idx];
        InstValid <= 1'b1;
        AddrErr   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Scoreboard bench for inst_mem_loadable: randomized loads and fetches checked
// against a word-array reference model.
module tb_inst_mem_loadable;
  import cpu_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        FetchEn = 1'b0;
  logic [31:0] ReadAddr = '0;
  logic [31:0] ReadInst;
  logic        InstValid, AddrErr;
  logic        LoadStart = 1'b0, LoadValid = 1'b0, LoadDone = 1'b0;
  logic [7:0]  LoadByte = '0;
  logic        LoadReady, Loading, LoadOverflow;
  logic [ADDR_W:0] WordCount;

  inst_mem_loadable #(.ADDR_W(ADDR_W), .DATA_W(32), .NOP_INST(32'h0)) dut (
    .clk(clk), .reset(reset), .FetchEn(FetchEn), .ReadAddr(ReadAddr),
    .ReadInst(ReadInst), .InstValid(InstValid), .AddrErr(AddrErr),
    .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadByte(LoadByte),
    .LoadReady(LoadReady), .LoadDone(LoadDone), .Loading(Loading),
    .LoadOverflow(LoadOverflow), .WordCount(WordCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic        err;
  } fexp_t;

  int          checks = 0;
  int          failures = 0;
  fexp_t       exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          known_hi = 0;
  int          exp_wc = 0;
  logic        exp_ovf = 1'b0;
  logic [7:0]  prog[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: decides from the stimulus seen at each edge what the fetch outputs must be.
  logic        mon_fe, mon_ls, mon_rs;
  logic [31:0] m_inst = '0;
  logic        m_valid = 1'b0, m_err = 1'b0;
  fexp_t       mon_e;

  always @(posedge clk) begin
    mon_fe = FetchEn;
    mon_ls = LoadStart;
    mon_rs = reset;
    #1;
    if (mon_rs) begin
      m_inst = '0; m_valid = 1'b0; m_err = 1'b0;
      exp_q.delete();
    end else if (mon_ls) begin
      m_inst = '0; m_valid = 1'b0;
    end else if (mon_fe) begin
      if (exp_q.size() == 0) begin
        check("fetch_queue_empty", 64'd0, 64'd1);
      end else begin
        mon_e   = exp_q.pop_front();
        m_inst  = mon_e.inst;
        m_valid = mon_e.valid;
        m_err   = mon_e.err;
      end
    end
    check("ReadInst", ReadInst, m_inst);
    check("InstValid", InstValid, m_valid);
    check("AddrErr", AddrErr, m_err);
  end

  // Reference model: words are groups of four bytes, first byte most significant,
  // missing tail bytes zero; only the first DEPTH words are stored.
  task automatic apply_load(input bit flush);
    int n, nw, stored;
    logic [31:0] w;
    n  = prog.size();
    nw = flush ? (n + 3) / 4 : n / 4;
    stored = (nw > DEPTH) ? DEPTH : nw;
    for (int i = 0; i < stored; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (4 * i + k < n)
          w = w | (32'(prog[4 * i + k]) << (24 - 8 * k));
      model_mem[i] = w;
    end
    if (stored > known_hi) known_hi = stored;
    exp_wc  = stored;
    exp_ovf = (n > 4 * DEPTH);
  endtask

  task automatic fetch_exp(input logic [31:0] a, input logic [31:0] inst, input bit use_model);
    fexp_t e;
    @(negedge clk);
    FetchEn  = 1'b1;
    ReadAddr = a;
    e.err   = (a % 4 != 0) || (a >= 4 * DEPTH);
    e.valid = !e.err;
    e.inst  = e.err ? 32'h0 : (use_model ? model_mem[a / 4] : inst);
    exp_q.push_back(e);
  endtask

  task automatic stall(input logic [31:0] a);
    @(negedge clk);
    FetchEn  = 1'b0;
    ReadAddr = a;
  endtask

  task automatic rand_fetch();
    int cat;
    logic [31:0] a;
    cat = $urandom_range(0, 9);
    if (cat < 7 && known_hi > 0) a = 32'($urandom_range(0, known_hi - 1)) * 4;
    else if (cat < 9) a = (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
    else begin
      a = $urandom;
      if ((a >> 11) == 0) a = a | 32'h800;
    end
    fetch_exp(a, 32'h0, 1'b1);
    if ($urandom_range(0, 2) == 0)
      repeat ($urandom_range(1, 3)) stall($urandom);
  endtask

  task automatic feed(input bit done_last, input bit gaps);
    for (int i = 0; i < prog.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        LoadValid = 1'b0;
        LoadDone  = 1'b0;
      end
      @(negedge clk);
      LoadValid = 1'b1;
      LoadByte  = prog[i];
      LoadDone  = done_last && (i == prog.size() - 1);
    end
    @(negedge clk);
    LoadValid = 1'b0;
    LoadDone  = 1'b0;
  endtask

  // mode 0: LoadDone with the last byte; mode 1: LoadDone one cycle after it.
  task automatic load_program(input int mode, input bit gaps);
    bit flush;
    @(negedge clk);
    FetchEn   = 1'b0;
    LoadStart = 1'b1;
    @(negedge clk);
    LoadStart = 1'b0;
    check("Loading_start", Loading, 1);
    check("WordCount_clear", WordCount, 0);
    check("LoadOverflow_clear", LoadOverflow, 0);
    check("LoadReady_load", LoadReady, 1);
    feed(mode == 0, gaps);
    if (mode == 1) begin
      LoadDone = 1'b1;
      @(negedge clk);
      LoadDone = 1'b0;
    end
    flush = (prog.size() <= 4 * DEPTH) && (prog.size() % 4 != 0);
    if (flush) begin
      check("Loading_flush", Loading, 1);
      check("LoadReady_flush", LoadReady, 0);
      @(negedge clk);
    end
    check("Loading_end", Loading, 0);
    apply_load(1'b1);
    check("WordCount", WordCount, 64'(exp_wc));
    check("LoadOverflow", LoadOverflow, 64'(exp_ovf));
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ReadInst", ReadInst, 0);
    check("rst_InstValid", InstValid, 0);
    check("rst_AddrErr", AddrErr, 0);
    check("rst_Loading", Loading, 0);
    check("rst_WordCount", WordCount, 0);
    check("rst_LoadOverflow", LoadOverflow, 0);
    reset = 1'b0;

    // Single-word program, latency, stall hold, address errors.
    prog = '{8'h20, 8'h04, 8'h00, 8'h05};
    load_program(0, 1'b0);
    fetch_exp(32'h0, 32'h2004_0005, 1'b0);
    repeat (3) stall(32'h4);
    fetch_exp(32'h2, 32'h0, 1'b0);
    fetch_exp(32'h800, 32'h0, 1'b0);
    fetch_exp(32'h0, 32'h2004_0005, 1'b0);
    stall(32'h0);

    // Partial-word flush.
    prog = '{8'h20, 8'h08, 8'h00, 8'h80, 8'hAC};
    load_program(1, 1'b0);
    check("flush_WordCount", WordCount, 2);
    fetch_exp(32'h0, 32'h2008_0080, 1'b0);
    fetch_exp(32'h4, 32'hAC00_0000, 1'b0);
    stall(32'h0);

    // Restart after three bytes: the partial word must not leak into the new load.
    @(negedge clk);
    LoadStart = 1'b1;
    @(negedge clk);
    LoadStart = 1'b0;
    prog = '{8'h11, 8'h22, 8'h33};
    feed(1'b0, 1'b0);
    prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load_program(0, 1'b0);
    fetch_exp(32'h0, 32'hDEAD_BEEF, 1'b0);
    fetch_exp(32'h4, 32'hAC00_0000, 1'b0);
    stall(32'h0);

    // Randomized programs and fetch traffic.
    for (int r = 0; r < 8; r++) begin
      rand_prog($urandom_range(1, 40));
      load_program($urandom_range(0, 1), 1'b1);
      repeat (15) rand_fetch();
      stall(32'h0);
    end

    // Fill the whole array and overrun it.
    rand_prog(4 * DEPTH + 6);
    load_program($urandom_range(0, 1), 1'b0);
    check("full_WordCount", WordCount, DEPTH);
    check("full_LoadOverflow", LoadOverflow, 1);
    repeat (20) rand_fetch();
    fetch_exp(32'(4 * (DEPTH - 1)), 32'h0, 1'b1);
    stall(32'h0);

    // Reset in the middle of the second word.
    @(negedge clk);
    LoadStart = 1'b1;
    @(negedge clk);
    LoadStart = 1'b0;
    check("restart_LoadOverflow", LoadOverflow, 0);
    rand_prog(6);
    feed(1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_Loading", Loading, 0);
    check("midrst_ReadInst", ReadInst, 0);
    check("midrst_WordCount", WordCount, 0);
    @(negedge clk);
    reset = 1'b0;
    apply_load(1'b0);
    fetch_exp(32'h0, 32'h0, 1'b1);
    fetch_exp(32'h4, 32'h0, 1'b1);
    fetch_exp(32'h8, 32'h0, 1'b1);
    repeat (10) rand_fetch();
    stall(32'h0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
